jpeg_mcu_sched: RTL and testbench

- Per-frame block scheduler for the entropy-coding stage.
- Takes a quantized, zigzagged 8x8 block from the block buffer and starts the DC Huffman encoder and the AC RLE/Huffman chain together for that block.
- Waits for both encoders to finish, then releases the buffer.
- Walks the component order of each MCU, selects the luma or chroma tables, clears the DC predictors and requests restart markers.

---
 rtl/jpeg_pkg.sv | 44 ++++
 rtl/jpeg_blk_done_join.sv | 50 +++++
 rtl/jpeg_mcu_sched.sv | 208 ++++++++++++++++++++
 tb/tb_jpeg_mcu_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG entropy-stage block scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jpeg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BLK,
        ST_START,
        ST_RUN,
        ST_NEXT,
        ST_RST_MRK,
        ST_DONE
    } mcu_state_t;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int BLK_444 = 3;
    localparam int BLK_420 = 6;

    // RSTn marker byte is RST_MARKER_BASE + n; the bit packer adds rst_idx.
    localparam logic [7:0] RST_MARKER_BASE = 8'hD0;

    // Component carried by a block position inside the MCU.
    // 4:4:4 -> Y Cb Cr ; 4:2:0 -> Y Y Y Y Cb Cr
    function automatic logic [1:0] comp_of_blk(input logic [2:0] blk_idx,
                                               input logic       subsamp);
        logic [1:0] comp;
        if (subsamp) begin
            comp = (blk_idx < 3'd4) ? COMP_Y : ((blk_idx == 3'd4) ? COMP_CB : COMP_CR);
        end else begin
            comp = (blk_idx == 3'd0) ? COMP_Y : ((blk_idx == 3'd1) ? COMP_CB : COMP_CR);
        end
        return comp;
    endfunction

    // Index of the final block of an MCU for the given sampling mode.
    function automatic logic [2:0] last_blk(input logic subsamp);
        return subsamp ? 3'(BLK_420 - 1) : 3'(BLK_444 - 1);
    endfunction

endpackage

// File: rtl/jpeg_blk_done_join.sv
// Joins two independent done pulses into one completion, with a watchdog.
// Latency: a done pulse is visible on both_done_o one cycle after it arrives.
// Backpressure: none; pulses are captured only while en_i is high.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   clr_i              clears both flags and the watchdog counter
//   en_i               capture window (flags latch and counter runs)
//   dc_done_i/ac_done_i  done pulses, any order, may coincide
//   both_done_o        both flags set
//   timeout_o          watchdog reached TIMEOUT_CYC cycles of en_i
module jpeg_blk_done_join #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic dc_done_i,
    input  logic ac_done_i,
    output logic both_done_o,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic             dc_flag_q;
    logic             ac_flag_q;
    logic [CNT_W-1:0] cnt_q;

    assign both_done_o = dc_flag_q & ac_flag_q;
    // Flag fires on the last counted cycle so the owner's reaction lands
    // exactly TIMEOUT_CYC cycles after the capture window opened.
    assign timeout_o   = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            dc_flag_q <= 1'b0;
            ac_flag_q <= 1'b0;
            cnt_q     <= '0;
        end else if (en_i) begin
            dc_flag_q <= dc_flag_q | dc_done_i;
            ac_flag_q <= ac_flag_q | ac_done_i;
            if (!both_done_o && !timeout_o) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/jpeg_mcu_sched.sv
// Per-frame block scheduler: walks MCU component order, starts DC/AC encoders, inserts RSTn.
// Latency: blk_rdy_i seen in WAIT_BLK -> go 2 cycles later; last done -> blk_ack_o 2 cycles later.
// Backpressure: waits on blk_rdy_i, on both encoder dones and on rst_mark_done_i.
//
// Ports:
//   clk_x8_i, rst_i                     clock, synchronous active-high reset
//   frame_start_i, cfg_*                frame kick and configuration (latched in IDLE)
//   blk_rdy_i / blk_ack_o               block buffer handshake
//   dc_go_o, ac_go_o, dc_done_i, ac_done_i   encoder start / completion
//   comp_id_o, tbl_sel_o, dc_pred_clr_o component, table select, predictor clear
//   rst_mark_o, rst_idx_o, rst_mark_done_i   restart marker request
//   mcu_cnt_o, busy_o, frame_done_o, err_o   status
module jpeg_mcu_sched
    import jpeg_pkg::*;
#(
    parameter int MCU_CNT_W   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk_x8_i,
    input  logic                 rst_i,
    input  logic                 frame_start_i,
    input  logic                 cfg_subsamp_i,
    input  logic [MCU_CNT_W-1:0] cfg_mcu_total_i,
    input  logic [MCU_CNT_W-1:0] cfg_rst_int_i,
    input  logic                 blk_rdy_i,
    output logic                 blk_ack_o,
    output logic                 dc_go_o,
    output logic                 ac_go_o,
    input  logic                 dc_done_i,
    input  logic                 ac_done_i,
    output logic [1:0]           comp_id_o,
    output logic                 tbl_sel_o,
    output logic                 dc_pred_clr_o,
    output logic                 rst_mark_o,
    output logic [2:0]           rst_idx_o,
    input  logic                 rst_mark_done_i,
    output logic [MCU_CNT_W-1:0] mcu_cnt_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 err_o
);

    mcu_state_t           state_q,    state_d;
    logic                 subsamp_q,  subsamp_d;
    logic [MCU_CNT_W-1:0] total_q,    total_d;
    logic [MCU_CNT_W-1:0] rst_int_q,  rst_int_d;
    logic [MCU_CNT_W-1:0] mcu_cnt_q,  mcu_cnt_d;
    logic [MCU_CNT_W-1:0] rst_cnt_q,  rst_cnt_d;
    logic [2:0]           blk_idx_q,  blk_idx_d;
    logic [2:0]           rst_idx_q,  rst_idx_d;
    logic                 err_q,      err_d;
    logic                 go_q,       go_d;
    logic                 pred_clr_q, pred_clr_d;
    logic                 fdone_q,    fdone_d;

    logic join_clr;
    logic both_done;
    logic timeout;
    logic blk_last;

    jpeg_blk_done_join #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_join (
        .clk_i       (clk_x8_i),
        .rst_i       (rst_i),
        .clr_i       (join_clr),
        .en_i        (state_q == ST_RUN),
        .dc_done_i   (dc_done_i),
        .ac_done_i   (ac_done_i),
        .both_done_o (both_done),
        .timeout_o   (timeout)
    );

    assign blk_last = (blk_idx_q == last_blk(subsamp_q));

    always_comb begin
        state_d    = state_q;
        subsamp_d  = subsamp_q;
        total_d    = total_q;
        rst_int_d  = rst_int_q;
        mcu_cnt_d  = mcu_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        blk_idx_d  = blk_idx_q;
        rst_idx_d  = rst_idx_q;
        err_d      = err_q;
        go_d       = 1'b0;
        pred_clr_d = 1'b0;
        fdone_d    = 1'b0;
        join_clr   = 1'b0;
        blk_ack_o  = 1'b0;
        rst_mark_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start_i) begin
                    subsamp_d  = cfg_subsamp_i;
                    total_d    = cfg_mcu_total_i;
                    rst_int_d  = cfg_rst_int_i;
                    err_d      = 1'b0;
                    mcu_cnt_d  = '0;
                    rst_cnt_d  = '0;
                    blk_idx_d  = '0;
                    rst_idx_d  = '0;
                    pred_clr_d = 1'b1;
                    state_d    = (cfg_mcu_total_i == '0) ? ST_DONE : ST_WAIT_BLK;
                end
            end
            ST_WAIT_BLK: begin
                if (blk_rdy_i) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // go is registered so it appears in the first RUN cycle;
                // clearing the join here drops any stray done seen now.
                go_d     = 1'b1;
                join_clr = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (both_done) begin
                    state_d = ST_NEXT;
                end else if (timeout) begin
                    // Keep draining the frame; the sticky flag reports it.
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                blk_ack_o = 1'b1;
                join_clr  = 1'b1;
                if (blk_last) begin
                    blk_idx_d = '0;
                    mcu_cnt_d = mcu_cnt_q + MCU_CNT_W'(1);
                    rst_cnt_d = rst_cnt_q + MCU_CNT_W'(1);
                end else begin
                    blk_idx_d = blk_idx_q + 3'd1;
                end
                // Frame end wins over restart, so no marker trails the last MCU.
                if (blk_last && (mcu_cnt_d == total_q)) begin
                    state_d = ST_DONE;
                end else if (blk_last && (rst_int_q != '0) && (rst_cnt_d == rst_int_q)) begin
                    state_d = ST_RST_MRK;
                end else begin
                    state_d = ST_WAIT_BLK;
                end
            end
            ST_RST_MRK: begin
                rst_mark_o = 1'b1;
                if (rst_mark_done_i) begin
                    rst_idx_d  = rst_idx_q + 3'd1;
                    rst_cnt_d  = '0;
                    pred_clr_d = 1'b1;
                    state_d    = ST_WAIT_BLK;
                end
            end
            ST_DONE: begin
                fdone_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_x8_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            subsamp_q  <= 1'b0;
            total_q    <= '0;
            rst_int_q  <= '0;
            mcu_cnt_q  <= '0;
            rst_cnt_q  <= '0;
            blk_idx_q  <= '0;
            rst_idx_q  <= '0;
            err_q      <= 1'b0;
            go_q       <= 1'b0;
            pred_clr_q <= 1'b0;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            subsamp_q  <= subsamp_d;
            total_q    <= total_d;
            rst_int_q  <= rst_int_d;
            mcu_cnt_q  <= mcu_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            blk_idx_q  <= blk_idx_d;
            rst_idx_q  <= rst_idx_d;
            err_q      <= err_d;
            go_q       <= go_d;
            pred_clr_q <= pred_clr_d;
            fdone_q    <= fdone_d;
        end
    end

    assign dc_go_o       = go_q;
    assign ac_go_o       = go_q;
    assign comp_id_o     = comp_of_blk(blk_idx_q, subsamp_q);
    assign tbl_sel_o     = (comp_id_o != COMP_Y);
    assign dc_pred_clr_o = pred_clr_q;
    assign rst_idx_o     = rst_idx_q;
    assign mcu_cnt_o     = mcu_cnt_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign frame_done_o  = fdone_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_jpeg_mcu_sched.sv
// Randomized bench for jpeg_mcu_sched: encoder/buffer/packer responders plus a
// frame-level reference model (expected block, marker and timing sequences).
// Outputs are sampled on the falling edge; inputs are driven right after.
module tb_jpeg_mcu_sched;

    localparam int W  = 16;
    localparam int TO = 16;

    logic         clk_x8_i = 1'b0;
    logic         rst_i, frame_start_i, cfg_subsamp_i;
    logic [W-1:0] cfg_mcu_total_i, cfg_rst_int_i;
    logic         blk_rdy_i, blk_ack_o, dc_go_o, ac_go_o, dc_done_i, ac_done_i;
    logic [1:0]   comp_id_o;
    logic         tbl_sel_o, dc_pred_clr_o, rst_mark_o, rst_mark_done_i;
    logic [2:0]   rst_idx_o;
    logic [W-1:0] mcu_cnt_o;
    logic         busy_o, frame_done_o, err_o;

    always #5 clk_x8_i = ~clk_x8_i;

    jpeg_mcu_sched #(.MCU_CNT_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk_x8_i        (clk_x8_i),
        .rst_i           (rst_i),
        .frame_start_i   (frame_start_i),
        .cfg_subsamp_i   (cfg_subsamp_i),
        .cfg_mcu_total_i (cfg_mcu_total_i),
        .cfg_rst_int_i   (cfg_rst_int_i),
        .blk_rdy_i       (blk_rdy_i),
        .blk_ack_o       (blk_ack_o),
        .dc_go_o         (dc_go_o),
        .ac_go_o         (ac_go_o),
        .dc_done_i       (dc_done_i),
        .ac_done_i       (ac_done_i),
        .comp_id_o       (comp_id_o),
        .tbl_sel_o       (tbl_sel_o),
        .dc_pred_clr_o   (dc_pred_clr_o),
        .rst_mark_o      (rst_mark_o),
        .rst_idx_o       (rst_idx_o),
        .rst_mark_done_i (rst_mark_done_i),
        .mcu_cnt_o       (mcu_cnt_o),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o),
        .err_o           (err_o)
    );

    logic [29:0] all_outs;
    assign all_outs = {blk_ack_o, dc_go_o, ac_go_o, comp_id_o, tbl_sel_o, dc_pred_clr_o,
                       rst_mark_o, rst_idx_o, mcu_cnt_o, busy_o, frame_done_o, err_o};

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, required %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk_x8_i);
        cyc++;
    endtask

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic quiet_inputs();
        frame_start_i   = 1'b0;
        blk_rdy_i       = 1'b0;
        dc_done_i       = 1'b0;
        ac_done_i       = 1'b0;
        rst_mark_done_i = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_i = 1'b1;
        tick();
        chk("reset_outputs", all_outs, 0);
        tick();
        rst_i = 1'b0;
    endtask

    // One frame. tmo: AC encoder never answers. abort_mcu >= 0: reset at the
    // go of the first block whose mcu_cnt equals abort_mcu.
    task automatic run_frame(input bit ss, input int total, input int rint,
                             input bit tmo, input int abort_mcu);
        int exp_comp[$];
        int mk_mcu[$];
        int mk_idx[$];
        int bpm, nblk, acks, clrs, marks, k, f, d1, d2;
        int wait_entry, rdy_cyc, exp_go, cur_comp, dc_due, ac_due, stray_due;
        int exp_ack, exp_clr, exp_mark_at, mark_due, exp_done_cyc;
        bit stray_dc, mark_active, err_exp, fin;

        bpm = ss ? 6 : 3;
        k = 0;
        for (int m = 1; m <= total; m++) begin
            for (int b = 0; b < bpm; b++)
                exp_comp.push_back(ss ? ((b < 4) ? 0 : b - 3) : b);
            if (rint != 0 && (m % rint) == 0 && m != total) begin
                mk_mcu.push_back(m);
                mk_idx.push_back(k % 8);
                k++;
            end
        end
        nblk = exp_comp.size();
        acks = 0; clrs = 0; marks = 0;
        exp_go = -1; cur_comp = 0; dc_due = -1; ac_due = -1; stray_due = -1; stray_dc = 0;
        exp_ack = -1; exp_mark_at = -1; mark_due = -1; mark_active = 0; err_exp = 0; fin = 0;

        cfg_subsamp_i   = ss;
        cfg_mcu_total_i = total[W-1:0];
        cfg_rst_int_i   = rint[W-1:0];
        frame_start_i   = 1'b1;
        f               = cyc;
        exp_clr         = f + 1;
        wait_entry      = (total > 0) ? f + 1 : -1;
        rdy_cyc         = (total > 0) ? f + 1 + rnd(0, 3) : -1;
        exp_done_cyc    = (total == 0) ? f + 2 : -1;

        while (!fin) begin
            tick();
            frame_start_i = 1'b0;

            if (cyc == f + 1) begin
                chk("err_cleared", err_o, 0);
                chk("busy_in_frame", busy_o, 1);
            end
            if (dc_pred_clr_o) begin
                clrs++;
                chk("pred_clr_cycle", cyc, exp_clr);
            end
            if (dc_go_o || ac_go_o) begin
                chk("go_pair", {dc_go_o, ac_go_o}, 2'b11);
                chk("go_cycle", cyc, exp_go);
                if (exp_comp.size() == 0) begin
                    chk("unexpected_go", 1, 0);
                    cur_comp = 0;
                end else begin
                    cur_comp = exp_comp.pop_front();
                end
                chk("comp_id", comp_id_o, cur_comp);
                chk("tbl_sel", tbl_sel_o, (cur_comp != 0));
                exp_go = -1;
                wait_entry = -1;
                if (abort_mcu >= 0 && int'(mcu_cnt_o) == abort_mcu) begin
                    do_reset();
                    return;
                end
                if (acks == 0) begin
                    // A second kick mid-frame must change nothing.
                    frame_start_i   = 1'b1;
                    cfg_mcu_total_i = '0;
                end
                if (tmo) begin
                    dc_due  = cyc + rnd(0, 5);
                    ac_due  = -1;
                    exp_ack = cyc + TO;
                    err_exp = 1;
                end else begin
                    d1 = rnd(0, 13);
                    d2 = ($urandom_range(1, 0) == 1) ? d1 : rnd(0, 13);
                    dc_due  = cyc + d1;
                    ac_due  = cyc + d2;
                    exp_ack = cyc + max2(d1, d2) + 2;
                end
            end
            if (blk_ack_o) begin
                chk("ack_cycle", cyc, exp_ack);
                chk("comp_stable", comp_id_o, cur_comp);
                chk("err_at_ack", err_o, err_exp);
                acks++;
                if (acks >= nblk) begin
                    rdy_cyc = -1;
                    exp_done_cyc = cyc + 2;
                end else begin
                    rdy_cyc = cyc + rnd(0, 3);
                    if ((acks % bpm) == 0 && mk_mcu.size() > 0 && mk_mcu[0] == acks / bpm)
                        exp_mark_at = cyc + 1;
                    else
                        wait_entry = cyc + 1;
                end
            end
            if (rst_mark_o && !mark_active) begin
                mark_active = 1;
                chk("marker_cycle", cyc, exp_mark_at);
                if (mk_mcu.size() == 0) begin
                    chk("unexpected_marker", 1, 0);
                end else begin
                    chk("rst_idx", rst_idx_o, mk_idx.pop_front());
                    chk("marker_mcu", mcu_cnt_o, mk_mcu.pop_front());
                end
                marks++;
                mark_due = cyc + rnd(0, 3);
            end
            if (mark_active && cyc == mark_due)
                chk("marker_hold", rst_mark_o, 1);
            if (frame_done_o) begin
                chk("frame_done_cycle", cyc, exp_done_cyc);
                chk("mcu_cnt_final", mcu_cnt_o, total);
                chk("idle_after_frame", busy_o, 0);
                chk("err_at_frame_done", err_o, err_exp);
                fin = 1;
            end
            if (cyc - f > 3000) begin
                chk("frame_cycle_budget", 0, 1);
                fin = 1;
            end

            dc_done_i = (cyc == dc_due) || (cyc == stray_due && stray_dc);
            ac_done_i = (cyc == ac_due) || (cyc == stray_due && !stray_dc);
            blk_rdy_i = (rdy_cyc >= 0) && (cyc >= rdy_cyc);
            rst_mark_done_i = mark_active && (cyc == mark_due);
            if (rst_mark_done_i) begin
                mark_active = 0;
                mark_due    = -1;
                wait_entry  = cyc + 1;
                exp_clr     = cyc + 1;
            end
            if (exp_go < 0 && wait_entry >= 0 && rdy_cyc >= 0) begin
                exp_go = max2(wait_entry, rdy_cyc) + 2;
                // Sometimes fire a done in the START cycle; it must be dropped.
                if (!tmo && $urandom_range(2, 0) == 0) begin
                    stray_due = exp_go - 1;
                    stray_dc  = ($urandom_range(1, 0) == 1);
                end else begin
                    stray_due = -1;
                end
            end
        end

        quiet_inputs();
        chk("ack_count", acks, nblk);
        chk("markers_left", mk_mcu.size(), 0);
        chk("pred_clr_count", clrs, 1 + marks);
    endtask

    initial begin
        rst_i           = 1'b1;
        cfg_subsamp_i   = 1'b0;
        cfg_mcu_total_i = '0;
        cfg_rst_int_i   = '0;
        quiet_inputs();
        repeat (3) tick();
        chk("reset_state", all_outs, 0);
        rst_i = 1'b0;
        tick();
        chk("idle_not_busy", busy_o, 0);

        run_frame(1'b0, 1, 0, 1'b0, -1);
        tick();
        run_frame(1'b1, 2, 0, 1'b0, -1);
        tick();
        run_frame(1'b0, 5, 2, 1'b0, -1);
        tick();
        run_frame(1'b0, 1, 0, 1'b1, -1);
        tick();
        run_frame(1'b0, 2, 1, 1'b0, -1);
        tick();
        run_frame(1'b0, 4, 1, 1'b0, 2);
        tick();
        tick();
        run_frame(1'b0, 4, 1, 1'b0, -1);
        tick();
        run_frame(1'b0, 0, 0, 1'b0, -1);
        tick();
        run_frame(1'b0, 10, 1, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            tick();
            run_frame(($urandom_range(1, 0) == 1), rnd(1, 4), rnd(0, 3), 1'b0, -1);
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
